// File: rtl/game_pio_pkg.sv
// Shared register map for the GameSystem Avalon-MM PIO blocks (input and output).
// Latency: n/a (constants only).
// Backpressure: n/a.
package game_pio_pkg;

    // Word addresses of the PIO register file
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Avalon data bus width
    localparam int PIO_DATA_W = 32;

endpackage : game_pio_pkg

// File: rtl/game_debounce_bit.sv
// One button bit: two-flop synchronizer, stability counter, debounced level and press pulse.
// Latency: level change visible on stable DEBOUNCE_CYCLES+2 cycles after the pin changes; rise one cycle wide.
// Backpressure: none; free-running per clock.
module game_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic p_raw,
    output logic stable,
    output logic rise
);

    // Counter only has to reach DEBOUNCE_CYCLES-1; one extra value of headroom keeps D=1 legal
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          p_sync;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            p_sync  <= 1'b0;
        end else begin
            sync_q1 <= p_raw;
            p_sync  <= sync_q1;
        end
    end

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (p_sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= p_sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Delayed copy of stable for press-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    // Only presses (0->1) are reported; releases are ignored
    assign rise = stable & ~stable_d;

endmodule : game_debounce_bit

// File: rtl/game_button_input_pio.sv
// Avalon-MM pushbutton input PIO: debounced DATA, W1C edge capture, maskable level IRQ.
// Latency: DATA DEBOUNCE_CYCLES+2 cycles after pin change, EDGECAP/irq one cycle later; reads zero-wait.
// Backpressure: none; slave always ready, writes take effect at the clock edge of the write.
module game_button_input_pio
    import game_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] p_raw;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic             wr_en;
    logic             unused_wdata;

    // Normalise polarity so that 1 always means pressed downstream
    assign p_raw = (ACTIVE_LOW != 0) ? ~in_port : in_port;

    // Only the low WIDTH bits of writedata carry register content
    assign unused_wdata = ^writedata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            game_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .p_raw   (p_raw[gi]),
                .stable  (stable[gi]),
                .rise    (rise[gi])
            );
        end
    endgenerate

    assign wr_en = chipselect && !write_n;

    // Interrupt mask register, loaded on a write to IRQMASK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: W1C clear first, then OR in new presses so a simultaneous set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
            edgecap <= (edgecap & ~writedata[WIDTH-1:0]) | rise;
        end else begin
            edgecap <= edgecap | rise;
        end
    end

    // Zero-wait read mux; unused upper bits and the DIR slot read as zero
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = stable;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:          readdata = '0;
        endcase
    end

    // Level interrupt straight from the registers, no added latency
    assign irq = |(edgecap & irqmask);

endmodule : game_button_input_pio

// File: tb/tb_game_button_input_pio.sv
// Directed bench for game_button_input_pio with WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Inputs are driven 1 ns after the rising edge; outputs are sampled a further 1 ns later.
// Register behaviour is table-driven; debounce timing corners are hand-written sequences.
module tb_game_button_input_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    game_button_input_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic        cs;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } reg_vec_t;

    reg_vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic cs, input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        logic [31:0] seen;

        vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,        2'd0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,        2'd1, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,        2'd2, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'hF,        2'd2, 32'hF, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd2, 32'hFFFFFFF5, 2'd2, 32'h5, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 32'hF,        2'd0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd1, 32'hF,        2'd1, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd3, 32'hF,        2'd3, 32'h0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 32'h0,        2'd2, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 32'hF,        2'd2, 32'h0, 1'b0};

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Reset state and register access table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].cs, vecs[i].waddr, vecs[i].wdata);
            chk_rd($sformatf("regvec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
            chk_irq($sformatf("regvec%0d_irq", i), vecs[i].exp_irq);
        end

        // Clean press on bit 0, mask 0
        in_port = 4'hE;
        tick(5);
        chk_rd("press_data_early", 2'd0, 32'h0);
        tick(1);
        chk_rd("press_data", 2'd0, 32'h1);
        chk_rd("press_cap_early", 2'd3, 32'h0);
        tick(1);
        chk_rd("press_cap", 2'd3, 32'h1);
        chk_irq("press_irq_masked", 1'b0);

        // Release: not captured; enabling mask with pending capture raises irq next cycle
        in_port = 4'hF;
        tick(8);
        chk_rd("release_data", 2'd0, 32'h0);
        chk_rd("release_cap", 2'd3, 32'h1);
        wr(1'b1, 2'd2, 32'h1);
        chk_irq("mask_on_irq", 1'b1);
        wr(1'b1, 2'd2, 32'h0);
        chk_irq("mask_off_irq", 1'b0);
        chk_rd("mask_off_cap_kept", 2'd3, 32'h1);
        wr(1'b1, 2'd3, 32'h1);
        chk_rd("w1c_cap", 2'd3, 32'h0);

        // Interrupt flow with mask set before the press
        wr(1'b1, 2'd2, 32'h1);
        chk_irq("irqflow_idle", 1'b0);
        in_port = 4'hE;
        tick(6);
        chk_irq("irqflow_pre", 1'b0);
        tick(1);
        chk_irq("irqflow_irq", 1'b1);
        wr(1'b1, 2'd3, 32'h1);
        chk_irq("irqflow_clr_irq", 1'b0);
        chk_rd("irqflow_clr_cap", 2'd3, 32'h0);
        in_port = 4'hF;
        tick(10);
        chk_rd("irqflow_release_cap", 2'd3, 32'h0);
        chk_irq("irqflow_release_irq", 1'b0);

        // Glitch rejection: 3-cycle pulse on bit 2
        seen = '0;
        in_port = 4'hB;
        tick(3);
        in_port = 4'hF;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            address = 2'd0;
            #1 seen = seen | readdata;
        end
        check("glitch3_data_seen", seen, 32'h0);
        chk_rd("glitch3_cap", 2'd3, 32'h0);

        // 5-cycle pulse on bit 2 is accepted
        seen = '0;
        in_port = 4'hB;
        tick(5);
        in_port = 4'hF;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            address = 2'd0;
            #1 seen = seen | readdata;
        end
        check("glitch5_data_seen", seen, 32'h4);
        chk_rd("glitch5_data_end", 2'd0, 32'h0);
        chk_rd("glitch5_cap", 2'd3, 32'h4);
        wr(1'b1, 2'd3, 32'hF);
        chk_rd("glitch5_cap_clr", 2'd3, 32'h0);

        // Set/clear collision on bit 1: W1C sampled on the same edge as rise
        in_port = 4'hD;
        tick(6);
        chk_rd("collide_data", 2'd0, 32'h2);
        wr(1'b1, 2'd3, 32'h2);
        chk_rd("collide_cap", 2'd3, 32'h2);
        in_port = 4'hF;
        tick(8);

        // Mid-debounce reset with irq active beforehand
        wr(1'b1, 2'd2, 32'h2);
        chk_irq("prereset_irq", 1'b1);
        in_port = 4'hE;
        tick(4);
        reset_n = 1'b0;
        #1;
        chk_irq("midreset_irq", 1'b0);
        chk_rd("midreset_data", 2'd0, 32'h0);
        chk_rd("midreset_mask", 2'd2, 32'h0);
        chk_rd("midreset_cap", 2'd3, 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        chk_rd("postreset_data_early", 2'd0, 32'h0);
        tick(1);
        chk_rd("postreset_data", 2'd0, 32'h1);
        tick(1);
        chk_rd("postreset_cap", 2'd3, 32'h1);
        chk_irq("postreset_irq", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_game_button_input_pio
